// File: rtl/mesh_drain_pkg.sv
// Shared types and width helpers for the mesh east-boundary drain collector.
package mesh_drain_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        STREAM  = 2'd1,
        DONE    = 2'd2
    } state_e;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mesh_drain_collector_if.sv
// Row-major result stream from the drain collector to the writeback path.
interface mesh_drain_collector_if
    import mesh_drain_pkg::*;
#(
    parameter int N          = 2,
    parameter int DATA_WIDTH = 32
);
    localparam int IW = idx_w(N);

    logic [DATA_WIDTH-1:0] result_o;
    logic [IW-1:0]         result_row_o;
    logic [IW-1:0]         result_col_o;
    logic                  result_valid_o;
    logic                  result_ready_i;
    logic                  result_last_o;

    modport master (
        output result_o,
        output result_row_o,
        output result_col_o,
        output result_valid_o,
        output result_last_o,
        input  result_ready_i
    );

    modport slave (
        input  result_o,
        input  result_row_o,
        input  result_col_o,
        input  result_valid_o,
        input  result_last_o,
        output result_ready_i
    );

endinterface

// File: rtl/mesh_drain_row_buf.sv
// One row of the result tile: fill counter plus N-entry buffer, filled right to left.
module mesh_drain_row_buf
    import mesh_drain_pkg::*;
#(
    parameter int N          = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clear,
    input  logic                  drain,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [idx_w(N)-1:0]   rd_col,
    output logic                  fill,
    output logic                  ovf_try,
    output logic [DATA_WIDTH-1:0] rd_data
);
    localparam int CW = cnt_w(N);

    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] mem [N];
    logic                  full;
    logic                  wr;

    assign full    = (cnt == CW'(N));
    assign wr      = en & drain & ~full;
    assign ovf_try = drain & ~wr;
    // Row counts as full after this cycle's beat lands.
    assign fill    = full | (wr & (cnt == CW'(N - 1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (wr) begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr & ~clear) begin
            for (int k = 0; k < N; k++) begin
                if (cnt == CW'(N - 1 - k)) begin
                    mem[k] <= data;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < N; k++) begin
            if (int'(rd_col) == k) begin
                rd_data = mem[k];
            end
        end
    end

endmodule

// File: rtl/mesh_drain_collector.sv
// Collects an NxN tile from the mesh east drain and streams it out row-major.
module mesh_drain_collector
    import mesh_drain_pkg::*;
#(
    parameter int N          = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [DATA_WIDTH-1:0] east_i [0:N-1],
    input  logic [N-1:0]          drain_i,
    input  logic                  clear_i,
    output logic                  collect_done_o,
    output logic                  busy_o,
    output logic                  overflow_o,
    mesh_drain_collector_if.master res
);
    localparam int             IW   = idx_w(N);
    localparam logic [IW-1:0]  LAST = IW'(N - 1);

    state_e                state;
    logic [IW-1:0]         rp_row;
    logic [IW-1:0]         rp_col;
    logic [N-1:0]          fill;
    logic [N-1:0]          ovf_try;
    logic [DATA_WIDTH-1:0] rd [N];
    logic [DATA_WIDTH-1:0] sel;
    logic                  collect;
    logic                  row_clr;
    logic                  valid;
    logic                  hs;
    logic                  at_last;

    assign collect = (state == COLLECT);
    assign row_clr = clear_i | (state == DONE);
    assign valid   = (state == STREAM);
    assign hs      = valid & res.result_ready_i;
    assign at_last = (rp_row == LAST) & (rp_col == LAST);

    for (genvar r = 0; r < N; r++) begin : g_row
        mesh_drain_row_buf #(
            .N          (N),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_row (
            .clk     (clk_i),
            .rst_n   (rstn_i),
            .en      (collect),
            .clear   (row_clr),
            .drain   (drain_i[r]),
            .data    (east_i[r]),
            .rd_col  (rp_col),
            .fill    (fill[r]),
            .ovf_try (ovf_try[r]),
            .rd_data (rd[r])
        );
    end

    always_comb begin
        sel = '0;
        for (int r = 0; r < N; r++) begin
            if (int'(rp_row) == r) begin
                sel = rd[r];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= COLLECT;
            rp_row     <= '0;
            rp_col     <= '0;
            overflow_o <= 1'b0;
        end else if (clear_i) begin
            state      <= COLLECT;
            rp_row     <= '0;
            rp_col     <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (|ovf_try) begin
                overflow_o <= 1'b1;
            end
            unique case (state)
                COLLECT: begin
                    if (&fill) begin
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (hs) begin
                        if (at_last) begin
                            state  <= DONE;
                            rp_row <= '0;
                            rp_col <= '0;
                        end else if (rp_col == LAST) begin
                            rp_col <= '0;
                            rp_row <= rp_row + IW'(1);
                        end else begin
                            rp_col <= rp_col + IW'(1);
                        end
                    end
                end
                DONE: begin
                    state  <= COLLECT;
                    rp_row <= '0;
                    rp_col <= '0;
                end
                default: state <= COLLECT;
            endcase
        end
    end

    // Buffer is unreset, so gate data to keep the bus quiet outside STREAM.
    assign res.result_o       = valid ? sel : '0;
    assign res.result_row_o   = rp_row;
    assign res.result_col_o   = rp_col;
    assign res.result_valid_o = valid;
    assign res.result_last_o  = valid & at_last;
    assign busy_o             = valid;
    assign collect_done_o     = (state == DONE);

endmodule
